// File: rtl/rgb_frame_gate_scheduler_if.sv
// ---------------------------------------------------------------------------
// rgb_frame_gate_scheduler_if
//
// Bundles the switch inputs, the frame pulse and the channel-gate outputs of
// rgb_frame_gate_scheduler.
//
//   sw_r/sw_g/sw_b  raw manual channel switches (asynchronous)
//   sw_auto         raw auto-test-mode switch (asynchronous)
//   frame_start     single-cycle pulse at the start of vertical blanking
//   en_r/en_g/en_b  registered channel enables toward the RGB output stage
//   auto_active     registered, high while an auto test state is active
//
// master: the side that drives switches/frame_start and observes enables.
// slave : the scheduler itself.
// ---------------------------------------------------------------------------
interface rgb_frame_gate_scheduler_if;
    logic sw_r;
    logic sw_g;
    logic sw_b;
    logic sw_auto;
    logic frame_start;
    logic en_r;
    logic en_g;
    logic en_b;
    logic auto_active;

    modport master (
        output sw_r, sw_g, sw_b, sw_auto, frame_start,
        input  en_r, en_g, en_b, auto_active
    );

    modport slave (
        input  sw_r, sw_g, sw_b, sw_auto, frame_start,
        output en_r, en_g, en_b, auto_active
    );
endinterface

// File: rtl/rgb_frame_gate_scheduler.sv
// ---------------------------------------------------------------------------
// rgb_frame_gate_scheduler
//
// Produces the per-channel enables that gate the R/G/B pixel buses. The raw
// switches are synchronized and debounced; channel changes are only applied
// on a frame_start pulse so no colour plane toggles mid-frame. An auto test
// mode steps R -> G -> B -> W, holding each for CYCLE_FRAMES frames.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles needed to accept a switch change (>=1)
//   CYCLE_FRAMES     frames each auto step is held (>=1)
// Ports
//   clk      rising-edge clock for all logic
//   reset_n  asynchronous active-low reset
//   bus      slave side of rgb_frame_gate_scheduler_if (switches,
//            frame_start in; en_r/en_g/en_b, auto_active out)
// ---------------------------------------------------------------------------
module rgb_frame_gate_scheduler #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int CYCLE_FRAMES    = 60
) (
    input  logic                        clk,
    input  logic                        reset_n,
    rgb_frame_gate_scheduler_if.slave   bus
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int FC_W  = (CYCLE_FRAMES > 1) ? $clog2(CYCLE_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(CYCLE_FRAMES - 1);

    // Switch index map: 0 = r, 1 = g, 2 = b, 3 = auto
    localparam int IDX_R    = 0;
    localparam int IDX_G    = 1;
    localparam int IDX_B    = 2;
    localparam int IDX_AUTO = 3;

    logic [3:0] raw;
    logic [3:0] deb;

    assign raw = {bus.sw_auto, bus.sw_b, bus.sw_g, bus.sw_r};

    // -----------------------------------------------------------------------
    // Per-switch 2-flop synchronizer followed by an independent debouncer.
    // The counter only runs while the synchronized value disagrees with the
    // accepted value; any return to the accepted value clears it.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_sw
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync1_reg <= 1'b0;
                    sync2_reg <= 1'b0;
                    deb_reg   <= 1'b0;
                    cnt_reg   <= '0;
                end else begin
                    sync1_reg <= raw[gi];
                    sync2_reg <= sync1_reg;
                    if (sync2_reg == deb_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        deb_reg <= sync2_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            assign deb[gi] = deb_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Frame-aligned mode FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_MANUAL = 3'd0,
        ST_AUTO_R = 3'd1,
        ST_AUTO_G = 3'd2,
        ST_AUTO_B = 3'd3,
        ST_AUTO_W = 3'd4
    } state_t;

    state_t          state_reg,       state_next;
    logic [FC_W-1:0] frame_cnt_reg,   frame_cnt_next;
    logic [2:0]      en_reg,          en_next;      // {r, g, b}
    logic            auto_active_reg, auto_active_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= ST_MANUAL;
            frame_cnt_reg   <= '0;
            en_reg          <= 3'b000;
            auto_active_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            frame_cnt_reg   <= frame_cnt_next;
            en_reg          <= en_next;
            auto_active_reg <= auto_active_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        frame_cnt_next   = frame_cnt_reg;
        en_next          = en_reg;
        auto_active_next = auto_active_reg;

        if (bus.frame_start) begin
            case (state_reg)
                ST_MANUAL: begin
                    if (deb[IDX_AUTO]) begin
                        state_next     = ST_AUTO_R;
                        frame_cnt_next = '0;
                    end
                end
                default: begin
                    if (!deb[IDX_AUTO]) begin
                        state_next     = ST_MANUAL;
                        frame_cnt_next = '0;
                    end else if (frame_cnt_reg == FC_LAST) begin
                        frame_cnt_next = '0;
                        case (state_reg)
                            ST_AUTO_R: state_next = ST_AUTO_G;
                            ST_AUTO_G: state_next = ST_AUTO_B;
                            ST_AUTO_B: state_next = ST_AUTO_W;
                            default:   state_next = ST_AUTO_R;
                        endcase
                    end else begin
                        frame_cnt_next = frame_cnt_reg + FC_W'(1);
                    end
                end
            endcase

            // Enables follow the state being entered, so a mode switch and
            // the new channel pattern land on the same frame boundary.
            case (state_next)
                ST_AUTO_R: en_next = 3'b100;
                ST_AUTO_G: en_next = 3'b010;
                ST_AUTO_B: en_next = 3'b001;
                ST_AUTO_W: en_next = 3'b111;
                default:   en_next = {deb[IDX_R], deb[IDX_G], deb[IDX_B]};
            endcase
            auto_active_next = (state_next != ST_MANUAL);
        end
    end

    assign bus.en_r        = en_reg[2];
    assign bus.en_g        = en_reg[1];
    assign bus.en_b        = en_reg[0];
    assign bus.auto_active = auto_active_reg;

endmodule

// File: tb/tb_rgb_frame_gate_scheduler.sv
module tb_rgb_frame_gate_scheduler;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    // DUT A: DEBOUNCE_CYCLES=4, CYCLE_FRAMES=3
    rgb_frame_gate_scheduler_if ifa ();
    // DUT B: DEBOUNCE_CYCLES=2, CYCLE_FRAMES=1
    rgb_frame_gate_scheduler_if ifb ();

    rgb_frame_gate_scheduler #(
        .DEBOUNCE_CYCLES (4),
        .CYCLE_FRAMES    (3)
    ) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifa.slave)
    );

    rgb_frame_gate_scheduler #(
        .DEBOUNCE_CYCLES (2),
        .CYCLE_FRAMES    (1)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (ifb.slave)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       r;
        logic       g;
        logic       b;
        logic [2:0] exp_en;
    } man_vec_t;

    man_vec_t   mv [5];
    logic [2:0] auto_seq [19];
    logic [2:0] one_seq  [5];

    // Observed value packed as {auto_active, en_r, en_g, en_b}
    function automatic logic [3:0] obs_a();
        return {ifa.auto_active, ifa.en_r, ifa.en_g, ifa.en_b};
    endfunction

    function automatic logic [3:0] obs_b();
        return {ifb.auto_active, ifb.en_r, ifb.en_g, ifb.en_b};
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {auto,r,g,b}=%b required %b", name, act, exp);
        end else begin
            $display("ok   %s: {auto,r,g,b}=%b", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_a();
        ifa.frame_start = 1'b1;
        tick(1);
        ifa.frame_start = 1'b0;
    endtask

    task automatic pulse_b();
        ifb.frame_start = 1'b1;
        tick(1);
        ifb.frame_start = 1'b0;
    endtask

    task automatic set_a(input logic r, input logic g, input logic b, input logic au);
        ifa.sw_r    = r;
        ifa.sw_g    = g;
        ifa.sw_b    = b;
        ifa.sw_auto = au;
    endtask

    initial begin
        logic [3:0] prev;

        mv[0] = '{r: 1'b0, g: 1'b1, b: 1'b1, exp_en: 3'b011};
        mv[1] = '{r: 1'b0, g: 1'b0, b: 1'b1, exp_en: 3'b001};
        mv[2] = '{r: 1'b1, g: 1'b1, b: 1'b1, exp_en: 3'b111};
        mv[3] = '{r: 1'b0, g: 1'b0, b: 1'b0, exp_en: 3'b000};
        mv[4] = '{r: 1'b1, g: 1'b0, b: 1'b1, exp_en: 3'b101};

        auto_seq = '{3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010,
                     3'b001, 3'b001, 3'b001, 3'b111, 3'b111, 3'b111,
                     3'b100, 3'b100, 3'b100, 3'b010, 3'b010, 3'b010,
                     3'b001};
        one_seq  = '{3'b100, 3'b010, 3'b001, 3'b111, 3'b100};

        reset_n = 1'b1;
        set_a(1'b0, 1'b0, 1'b0, 1'b0);
        ifa.frame_start = 1'b0;
        ifb.sw_r = 1'b0; ifb.sw_g = 1'b0; ifb.sw_b = 1'b0; ifb.sw_auto = 1'b0;
        ifb.frame_start = 1'b0;

        #2 reset_n = 1'b0;
        tick(3);
        check("reset_a", obs_a(), 4'b0000);
        check("reset_b", obs_b(), 4'b0000);
        reset_n = 1'b1;
        tick(4);
        check("no_change_before_frame", obs_a(), 4'b0000);
        pulse_a();
        check("first_frame_all_off", obs_a(), 4'b0000);

        // Debounce reject: 3-cycle glitch on sw_r
        ifa.sw_r = 1'b1;
        tick(3);
        ifa.sw_r = 1'b0;
        tick(8);
        pulse_a();
        check("glitch_rejected", obs_a(), 4'b0000);

        // Debounce accept; deb_r updates on the 6th edge after the raw change.
        // A frame sampled on that edge still sees the old value; the next one
        // sees the new value.
        ifa.sw_r = 1'b1;
        tick(5);
        pulse_a();
        check("frame_with_deb_update_uses_old", obs_a(), 4'b0000);
        pulse_a();
        check("accept_next_frame", obs_a(), 4'b0100);

        // Frame alignment: deb_g rises mid-frame, enables must hold
        ifa.sw_g = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check($sformatf("midframe_hold_%0d", i), obs_a(), 4'b0100);
            tick(1);
        end
        pulse_a();
        check("midframe_applied", obs_a(), 4'b0110);

        // Table-driven manual vectors
        prev = obs_a();
        prev = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            set_a(mv[i].r, mv[i].g, mv[i].b, 1'b0);
            tick(8);
            check($sformatf("vec%0d_hold", i), obs_a(), prev);
            pulse_a();
            check($sformatf("vec%0d_apply", i), obs_a(), {1'b0, mv[i].exp_en});
            prev = {1'b0, mv[i].exp_en};
        end

        // Auto cycling; manual switches change together with sw_auto
        set_a(1'b1, 1'b1, 1'b0, 1'b1);
        tick(8);
        for (int i = 0; i < 19; i++) begin
            pulse_a();
            check($sformatf("auto_frame_%0d", i + 1), obs_a(), {1'b1, auto_seq[i]});
            tick(2);
        end

        // Auto exit from AUTO_B
        ifa.sw_auto = 1'b0;
        tick(8);
        check("auto_exit_hold", obs_a(), 4'b1001);
        pulse_a();
        check("auto_exit_manual", obs_a(), 4'b0110);

        // Re-entry restarts at AUTO_R with a full hold
        ifa.sw_auto = 1'b1;
        tick(8);
        pulse_a();
        check("reentry_r1", obs_a(), 4'b1100);
        pulse_a();
        check("reentry_r2", obs_a(), 4'b1100);
        pulse_a();
        check("reentry_r3", obs_a(), 4'b1100);
        pulse_a();
        check("reentry_g1", obs_a(), 4'b1010);

        // Asynchronous reset mid-operation (between clock edges)
        #2;
        reset_n = 1'b0;
        set_a(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        check("async_reset_immediate", obs_a(), 4'b0000);
        tick(2);
        reset_n = 1'b1;
        tick(2);
        pulse_a();
        check("after_reset_frame", obs_a(), 4'b0000);

        // CYCLE_FRAMES=1: advance on every frame
        ifb.sw_auto = 1'b1;
        tick(6);
        for (int i = 0; i < 5; i++) begin
            pulse_b();
            check($sformatf("cf1_frame_%0d", i + 1), obs_b(), {1'b1, one_seq[i]});
            tick(1);
        end

        // sw_auto drop and manual change together take effect at one frame
        ifb.sw_auto = 1'b0;
        ifb.sw_g    = 1'b1;
        tick(6);
        check("cf1_exit_hold", obs_b(), 4'b1100);
        pulse_b();
        check("cf1_exit_manual", obs_b(), 4'b0010);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
